flp_min_stream: RTL and testbench
=================================

// Module: flp_min_stream
// PURPOSE
//  Streaming floating-point minimum reducer; the min-direction, sequential complement of the FP max selector.
//  Consumes a packet of IEEE-style sign-magnitude values over valid/ready and tracks min value + first index.
//  Emits one result beat per packet (value, index, count, NaN flag). Sits after FP datapaths for argmin/clamp.
// PARAMETERS
//  Bits   32  total FP width (16 for half)
//  EXP_W  8   exponent field width (5 for half); mantissa = Bits-1-EXP_W
//  IDX_W  16  width of element index/count
// PORTS
//  clk      in   1      rising-edge clock
//  rst_n    in   1      asynchronous active-low reset
//  s_valid  in   1      input beat valid
//  s_ready  out  1      input beat accepted when s_valid&s_ready
//  s_data   in   Bits   FP operand
//  s_last   in   1      final beat of packet
//  m_valid  out  1      result valid
//  m_ready  in   1      result consumed when m_valid&m_ready
//  m_min    out  Bits   minimum non-NaN value of packet
//  m_idx    out  IDX_W  zero-based index of first occurrence of m_min
//  m_count  out  IDX_W  number of beats in packet (saturating)
//  m_nan    out  1      at least one NaN seen in packet
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, s_ready=0 during reset; m_valid=0, m_min=0, m_idx=0, m_count=0, m_nan=0.
//  FSM: IDLE -> ACC on first accepted beat (non-last); IDLE/ACC -> OUT on accepted beat with s_last=1;
//   OUT -> IDLE when m_valid&m_ready. s_ready=1 in IDLE and ACC, 0 in OUT (no input accepted while result pending).
//  Latency: m_valid asserts the cycle after the s_last beat is accepted; held with outputs stable until m_ready.
//  Back-to-back: next packet's first beat may be accepted in the cycle after the result handshake (1 bubble).
//  Ordering (x<y): sign-magnitude total order: neg<pos; both pos -> smaller magnitude; both neg -> larger magnitude.
//   -0 < +0. Infinities ordered naturally (-inf smallest, +inf largest non-NaN).
//  Ties (equal bit patterns): keep earlier index; candidate replaces stored min only if strictly less.
//  NaN (exp all ones, mantissa!=0): excluded from compare, sets sticky m_nan; still counted and indexed.
//  All-NaN packet: m_min = canonical qNaN {0, all-ones exp, MSB mantissa=1, rest 0}, m_idx=0, m_nan=1.
//  First non-NaN beat of packet loads min unconditionally (no compare against stale/reset value).
//  Index counter: increments per accepted beat; saturates at 2^IDX_W-1 (no wrap); m_count = beats, saturating.
//   Beats past saturation still compared; if one wins, m_idx reports the saturated value.
//  Single-beat packet (s_last on first beat): m_min=that value, m_idx=0, m_count=1.
//  s_valid=0 mid-packet: state and accumulators hold; no timeout.
//  Reset mid-packet or with m_valid high: partial result discarded, returns to reset values immediately.
//  Compare is single-cycle combinational on registered min; one beat per cycle sustained throughput.
// TESTING
//  1) Bits=32: beats 3.0,1.5,-2.0,7.0(last) -> m_min=0xC0000000, m_idx=2, m_count=4, m_nan=0, m_valid 1 cycle after last.
//  2) Ties/zero: +0,-0,-0(last) -> m_min=0x80000000, m_idx=1 (first -0), m_count=3.
//  3) NaN: 0x7FC00001, 5.0, 0x7F800001(last) -> m_min=0x40A00000, m_idx=1, m_nan=1; all-NaN -> m_min=0x7FC00000, m_idx=0.
//  4) Backpressure: hold m_ready=0 10 cycles -> s_ready=0, outputs stable; m_ready=1 -> IDLE, next packet accepted next cycle.
//  5) Gaps + single beat: s_valid toggled randomly in packet gives same result as gapless; single -inf(last) -> 0xFF800000, idx 0, count 1.
//  6) Reset: assert rst_n=0 after 2 of 4 beats -> all outputs 0 async; fresh packet afterwards yields correct standalone result.

Source files
------------

// File: rtl/flp_min_stream.sv
// Streaming sign-magnitude floating-point minimum reducer.
// Tracks the minimum non-NaN value, the index of its first occurrence, the beat count and a
// sticky NaN flag across a packet, then presents one result beat.
module flp_min_stream #(
  parameter int unsigned Bits  = 32,
  parameter int unsigned EXP_W = 8,
  parameter int unsigned IDX_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [Bits-1:0]  s_data,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [Bits-1:0]  m_min,
  output logic [IDX_W-1:0] m_idx,
  output logic [IDX_W-1:0] m_count,
  output logic             m_nan
);

  localparam int unsigned MAN_W = Bits - 1 - EXP_W;
  localparam logic [IDX_W-1:0] IdxMax = '1;
  localparam logic [Bits-1:0] QNan = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StAcc, StOut} state_e;

  state_e           state_q;
  logic             s_ready_q;
  logic             m_valid_q;
  logic [Bits-1:0]  m_min_q;
  logic [IDX_W-1:0] m_idx_q;
  logic [IDX_W-1:0] m_count_q;
  logic             m_nan_q;

  // Packet accumulators
  logic [Bits-1:0]  min_q;
  logic [IDX_W-1:0] best_q;
  logic [IDX_W-1:0] cnt_q;
  logic             have_q;
  logic             nan_q;

  logic             accept;
  logic             in_nan;
  logic             less;
  logic             take;
  logic [Bits-1:0]  min_d;
  logic [IDX_W-1:0] best_d;
  logic [IDX_W-1:0] cnt_d;
  logic             have_d;
  logic             nan_d;

  assign accept = s_valid & s_ready_q;
  assign in_nan = (&s_data[Bits-2 -: EXP_W]) & (|s_data[MAN_W-1:0]);

  always_comb begin
    less = 1'b0;
    if (s_data[Bits-1] != min_q[Bits-1]) begin
      less = s_data[Bits-1];
    end else if (!s_data[Bits-1]) begin
      less = s_data[Bits-2:0] < min_q[Bits-2:0];
    end else begin
      // Both negative: larger magnitude is the smaller value
      less = s_data[Bits-2:0] > min_q[Bits-2:0];
    end
  end

  always_comb begin
    take   = !in_nan && (!have_q || less);
    min_d  = take ? s_data : min_q;
    best_d = take ? cnt_q : best_q;
    cnt_d  = (cnt_q == IdxMax) ? IdxMax : cnt_q + 1'b1;
    have_d = have_q | ~in_nan;
    nan_d  = nan_q | in_nan;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
      m_min_q   <= '0;
      m_idx_q   <= '0;
      m_count_q <= '0;
      m_nan_q   <= 1'b0;
      min_q     <= '0;
      best_q    <= '0;
      cnt_q     <= '0;
      have_q    <= 1'b0;
      nan_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StAcc: begin
          s_ready_q <= 1'b1;
          if (accept) begin
            if (s_last) begin
              state_q   <= StOut;
              s_ready_q <= 1'b0;
              m_valid_q <= 1'b1;
              m_min_q   <= have_d ? min_d : QNan;
              m_idx_q   <= have_d ? best_d : '0;
              m_count_q <= cnt_d;
              m_nan_q   <= nan_d;
              min_q     <= '0;
              best_q    <= '0;
              cnt_q     <= '0;
              have_q    <= 1'b0;
              nan_q     <= 1'b0;
            end else begin
              state_q <= StAcc;
              min_q   <= min_d;
              best_q  <= best_d;
              cnt_q   <= cnt_d;
              have_q  <= have_d;
              nan_q   <= nan_d;
            end
          end
        end
        StOut: begin
          if (m_ready) begin
            state_q   <= StIdle;
            m_valid_q <= 1'b0;
            s_ready_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign s_ready = s_ready_q;
  assign m_valid = m_valid_q;
  assign m_min   = m_min_q;
  assign m_idx   = m_idx_q;
  assign m_count = m_count_q;
  assign m_nan   = m_nan_q;

endmodule

// File: tb/tb_flp_min_stream.sv
// Directed bench for flp_min_stream: hand-computed packets, backpressure, gaps and reset.
module tb_flp_min_stream;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_data = '0;
  logic        s_last = 1'b0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [31:0] m_min;
  logic [15:0] m_idx;
  logic [15:0] m_count;
  logic        m_nan;

  int n_assert = 0;
  int n_fail   = 0;

  flp_min_stream #(.Bits(32), .EXP_W(8), .IDX_W(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_last  (s_last),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_min   (m_min),
    .m_idx   (m_idx),
    .m_count (m_count),
    .m_nan   (m_nan)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive one beat and return #1 after the edge that accepts it.
  task automatic send(input logic [31:0] d, input logic l);
    int n = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    while (!s_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) chk("s_ready_timeout", {31'b0, s_ready}, 32'd1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic chk_res(input string tag, input logic [31:0] emin, input logic [15:0] eidx,
                         input logic [15:0] ecnt, input logic enan);
    chk({tag, "_valid"}, {31'b0, m_valid}, 32'd1);
    chk({tag, "_min"}, m_min, emin);
    chk({tag, "_idx"}, {16'b0, m_idx}, {16'b0, eidx});
    chk({tag, "_count"}, {16'b0, m_count}, {16'b0, ecnt});
    chk({tag, "_nan"}, {31'b0, m_nan}, {31'b0, enan});
  endtask

  task automatic handshake();
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    chk("hs_mvalid_low", {31'b0, m_valid}, 32'd0);
    chk("hs_sready_high", {31'b0, s_ready}, 32'd1);
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_sready", {31'b0, s_ready}, 32'd0);
    chk("rst_mvalid", {31'b0, m_valid}, 32'd0);
    chk("rst_min", m_min, 32'd0);
    chk("rst_count", {16'b0, m_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1) Basic: 3.0, 1.5, -2.0, 7.0
    send(32'h40400000, 1'b0);
    send(32'h3FC00000, 1'b0);
    send(32'hC0000000, 1'b0);
    chk("t1_no_early_valid", {31'b0, m_valid}, 32'd0);
    send(32'h40E00000, 1'b1);
    chk_res("t1", 32'hC0000000, 16'd2, 16'd4, 1'b0);
    chk("t1_sready_low", {31'b0, s_ready}, 32'd0);
    handshake();

    // 2) Signed zeros and ties: +0, -0, -0
    send(32'h00000000, 1'b0);
    send(32'h80000000, 1'b0);
    send(32'h80000000, 1'b1);
    chk_res("t2", 32'h80000000, 16'd1, 16'd3, 1'b0);
    handshake();

    // 2b) Negative ordering: -1.0, -3.0, -3.0, 2.0
    send(32'hBF800000, 1'b0);
    send(32'hC0400000, 1'b0);
    send(32'hC0400000, 1'b0);
    send(32'h40000000, 1'b1);
    chk_res("t2b", 32'hC0400000, 16'd1, 16'd4, 1'b0);
    handshake();

    // 3) NaNs excluded but flagged
    send(32'h7FC00001, 1'b0);
    send(32'h40A00000, 1'b0);
    send(32'h7F800001, 1'b1);
    chk_res("t3", 32'h40A00000, 16'd1, 16'd3, 1'b1);
    handshake();

    // 3b) All-NaN packet
    send(32'h7F800001, 1'b0);
    send(32'hFFC00000, 1'b1);
    chk_res("t3b", 32'h7FC00000, 16'd0, 16'd2, 1'b1);
    handshake();

    // 3c) +inf is not NaN
    send(32'h7F800000, 1'b0);
    send(32'h7F800000, 1'b1);
    chk_res("t3c", 32'h7F800000, 16'd0, 16'd2, 1'b0);
    handshake();

    // 4) Backpressure: 1.0, -1.0 with m_ready held low
    send(32'h3F800000, 1'b0);
    send(32'hBF800000, 1'b1);
    s_valid = 1'b1;
    s_data  = 32'h00000000;
    s_last  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("t4_sready_low", {31'b0, s_ready}, 32'd0);
      chk("t4_min_stable", m_min, 32'hBF800000);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    chk_res("t4", 32'hBF800000, 16'd1, 16'd2, 1'b0);
    handshake();
    send(32'h42000000, 1'b1);
    chk_res("t4_next", 32'h42000000, 16'd0, 16'd1, 1'b0);
    handshake();

    // 5) Gaps between beats give the gapless result
    begin
      logic [31:0] vec [4];
      vec[0] = 32'h40400000;
      vec[1] = 32'h3FC00000;
      vec[2] = 32'hC0000000;
      vec[3] = 32'h40E00000;
      for (int i = 0; i < 4; i++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
        send(vec[i], i == 3);
      end
    end
    chk_res("t5", 32'hC0000000, 16'd2, 16'd4, 1'b0);
    handshake();
    send(32'hFF800000, 1'b1);
    chk_res("t5_single", 32'hFF800000, 16'd0, 16'd1, 1'b0);
    handshake();

    // 6) Reset mid-packet discards partial state
    send(32'h40400000, 1'b0);
    send(32'h3FC00000, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_sready", {31'b0, s_ready}, 32'd0);
    chk("t6_mvalid", {31'b0, m_valid}, 32'd0);
    chk("t6_min", m_min, 32'd0);
    chk("t6_idx", {16'b0, m_idx}, 32'd0);
    chk("t6_count", {16'b0, m_count}, 32'd0);
    chk("t6_nan", {31'b0, m_nan}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send(32'h41100000, 1'b0);
    send(32'h40800000, 1'b1);
    chk_res("t6_fresh", 32'h40800000, 16'd1, 16'd2, 1'b0);

    // 6b) Reset while result pending
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6b_mvalid", {31'b0, m_valid}, 32'd0);
    chk("t6b_min", m_min, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send(32'hC1200000, 1'b1);
    chk_res("t6b_fresh", 32'hC1200000, 16'd0, 16'd1, 1'b0);
    handshake();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
